core_mem_slave: RTL and testbench
=================================

# core_mem_slave

Membus slave emulating one PDP-6 core memory module, sitting downstream of the Avalon-to-membus bridge on the shared membus. It decodes the memory selection and address, acknowledges the cycle, and returns read data on the OR-ed read bus. For write and read-modify-write cycles it collects the write word from the bus, then commits it to an internal 36-bit RAM. It also enforces core-style cycle recovery so back-to-back requests are serialised.

## Interface
Parameters:
- SEL, 4'o0, memory number; module responds only when m_sel == SEL and m_fmc_select == 0
- ADDR_BITS, 14, implemented words = 2^ADDR_BITS (1..15); uses m_ma low ADDR_BITS bits; responds only if the remaining high ma bits are 0
- REC_CYC, 12, idle recovery cycles after each cycle (0 allowed)
- WR_TMO, 255, cycles to wait for m_wr_rs before restoring

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- m_rq_cyc  in  1  cycle request, level, held until ack seen
- m_rd_rq  in  1  read request
- m_wr_rq  in  1  write request (both set = read-modify-write)
- m_ma  in  [21:35]  word address
- m_sel  in  [18:21]  memory select
- m_fmc_select  in  1  fast memory select; 1 = not for this module
- m_mb_write  in  [0:35]  write data, OR-bus, pulsed
- m_wr_rs  in  1  write restart pulse
- m_mb_read  out  [0:35]  read data, zero except in RDRS
- m_addr_ack  out  1  address acknowledge
- m_rd_rs  out  1  read restart, one-cycle pulse

## Operation
- Reset: state IDLE, data register 0, all outputs 0, recovery/timeout counters 0, no RAM write.
- Select = m_rq_cyc & (m_rd_rq | m_wr_rq) & ~m_fmc_select & m_sel == SEL & high ma bits == 0.
- IDLE: on select, latch address and the rd/wr flags, clear the data register, and go to ACK.
- ACK:
  - m_addr_ack = 1.
  - Hold while m_rq_cyc = 1.
  - Once m_rq_cyc = 0, go to READ if the rd flag is set, else WWAIT.
- READ: issue the RAM read (1-cycle latency). Next cycle, load the data register and go to RDRS.
- RDRS:
  - m_rd_rs = 1 and m_mb_read = data register, for exactly 1 cycle.
  - Then go to WWAIT if the wr flag is set, else REC. A pure read does no RAM write, because the RAM is non-destructive.
- WWAIT:
  - For read-modify-write, clear the data register on entry, because write data replaces the read word.
  - Every cycle, data register |= m_mb_write.
  - On m_wr_rs, go to WRITE.
  - On timeout after WR_TMO cycles, go to WRITE with the register unchanged (zero for a pure write). The timeout counter clears on entry.
- WRITE: data register |= m_mb_write this cycle. Next cycle, write the register to RAM[addr] and go to REC.
- REC: count REC_CYC cycles, then return to IDLE. Requests arriving meanwhile wait; since m_rq_cyc is level, they are not lost.
- Unselected requests are ignored entirely; all outputs stay 0.
- m_wr_rs or m_mb_write outside WWAIT/WRITE has no effect.

## Timing
- Latency from select to m_addr_ack: 1 cycle (registered).
- m_addr_ack falls 1 cycle after m_rq_cyc is sampled low.
- Read: m_rd_rs is high 3 cycles after the m_addr_ack falling edge (ACK exit, READ, RAM latency).
- Write data is captured from WWAIT entry through the cycle after m_wr_rs, which covers a 2-cycle m_mb_write pulse overlapping m_wr_rs.
- RAM write completes 2 cycles after m_wr_rs.
- Minimum spacing between successive m_addr_ack rising edges: the full cycle length + REC_CYC + 1.
- All outputs are registered; no combinational path from inputs to outputs.
- Asynchronous reset mid-cycle aborts to IDLE immediately; the RAM is left unmodified.

## Structure
- Shared include: state encoding (IDLE, ACK, READ, RDRS, WWAIT, WRITE, REC), 36-bit word width, membus field widths.
- Sub-module core_ram: 36 x 2^ADDR_BITS single-port synchronous RAM, 1-cycle read latency, write enable, no reset on contents.
- Top: FSM, address/flag/data registers, recovery and timeout counters, output registers.

## Test plan
- Write then read:
  - Write cycle to SEL=0, ma=0o1234, with wr_rs plus 2-cycle mb_write = 0o123456_654321.
  - Then a read cycle to the same address returns m_mb_read = 0o123456654321 with a single m_rd_rs pulse.
- Read-modify-write: RAM[5] = 0o777, rd+wr to ma=5 gives m_rd_rs with 0o777; writing 0o1 then leaves RAM[5] = 0o1, not 0o777.
- Select filtering: m_sel = SEL+1, m_fmc_select = 1, or ma with a high bit set gives no m_addr_ack, no m_rd_rs, and m_mb_read = 0 throughout.
- Write timeout: write cycle with no m_wr_rs gives a RAM write of 0 after WR_TMO cycles, then REC; a subsequent read returns 0.
- Back-to-back: second request raised immediately after the first ack; the second m_addr_ack appears only after REC_CYC recovery cycles.
- Reset mid-WWAIT: RAM[7] = 0o55; start a write to 7, pulse reset before wr_rs. All outputs are 0 at once and a later read returns 0o55.

Source files
------------

// File: rtl/core_mem_slave_pkg.sv
// core_mem_slave shared types: cycle state encoding and membus field widths.
// Imported by the RAM and the slave top.
package core_mem_slave_pkg;

  localparam int WORD_W = 36;
  localparam int MA_W   = 15;
  localparam int SEL_W  = 4;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    ACK,
    READ,
    RDRS,
    WWAIT,
    WRITE,
    REC
  } state_t;

endpackage

// File: rtl/core_mem_slave_ram.sv
// core_ram: 36 x 2^ADDR_BITS single-port synchronous core store.
// Ports: clk, re/we strobes, addr, wdata in; rdata out (1-cycle latency).
module core_ram
  import core_mem_slave_pkg::*;
#(
  parameter int ADDR_BITS = 14
) (
  input  logic                 clk,
  input  logic                 re,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  word_t                wdata,
  output word_t                rdata
);

  word_t mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/core_mem_slave.sv
// core_mem_slave: membus slave emulating one PDP-6 core memory module.
// Ports: clk, reset (async low), m_rq_cyc/m_rd_rq/m_wr_rq, m_ma, m_sel,
// m_fmc_select, m_mb_write, m_wr_rs in; m_mb_read, m_addr_ack, m_rd_rs out.
// Bus vectors use index 0 = PDP bit 35 (LSB), so m_ma[14] is PDP ma bit 21.
module core_mem_slave
  import core_mem_slave_pkg::*;
#(
  parameter logic [3:0] SEL       = 4'o0,
  parameter int         ADDR_BITS = 14,
  parameter int         REC_CYC   = 12,
  parameter int         WR_TMO    = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m_rq_cyc,
  input  logic              m_rd_rq,
  input  logic              m_wr_rq,
  input  logic [MA_W-1:0]   m_ma,
  input  logic [SEL_W-1:0]  m_sel,
  input  logic              m_fmc_select,
  input  logic [WORD_W-1:0] m_mb_write,
  input  logic              m_wr_rs,
  output logic [WORD_W-1:0] m_mb_read,
  output logic              m_addr_ack,
  output logic              m_rd_rs
);

  state_t state;
  state_t nstate;
  state_t rec_next;

  logic [ADDR_BITS-1:0] addr_q;
  logic                 rd_q;
  logic                 wr_q;
  word_t                data_q;
  logic                 ph_q;
  logic [31:0]          rec_cnt;
  logic [31:0]          tmo_cnt;
  word_t                ram_q;
  word_t                read_q;
  logic                 ack_q;
  logic                 rd_rs_q;

  logic hi_ok;
  logic sel_hit;
  logic tmo_done;
  logic rec_done;
  logic ram_re;
  logic ram_we;

  assign hi_ok = (32'(m_ma) >> ADDR_BITS) == 32'd0;

  assign sel_hit = m_rq_cyc
                 & (m_rd_rq | m_wr_rq)
                 & ~m_fmc_select
                 & (m_sel == SEL)
                 & hi_ok;

  assign tmo_done = (tmo_cnt + 32'd1) >= 32'(WR_TMO);
  assign rec_done = (rec_cnt + 32'd1) >= 32'(REC_CYC);
  assign rec_next = (REC_CYC == 0) ? IDLE : REC;

  // READ and WRITE each span two cycles; ph_q marks the second one.
  assign ram_re = (state == READ) && !ph_q;
  assign ram_we = (state == WRITE) && ph_q;

  core_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk   (clk),
    .re    (ram_re),
    .we    (ram_we),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (ram_q)
  );

  always_comb begin
    nstate = state;
    unique case (state)
      IDLE:  if (sel_hit) nstate = ACK;
      ACK:   if (!m_rq_cyc) nstate = rd_q ? READ : WWAIT;
      READ:  if (ph_q) nstate = RDRS;
      RDRS:  nstate = wr_q ? WWAIT : rec_next;
      WWAIT: if (m_wr_rs || tmo_done) nstate = WRITE;
      WRITE: if (ph_q) nstate = rec_next;
      REC:   if (rec_done) nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      ph_q    <= 1'b0;
      rec_cnt <= '0;
      tmo_cnt <= '0;
      ack_q   <= 1'b0;
      rd_rs_q <= 1'b0;
      read_q  <= '0;
    end else begin
      state   <= nstate;
      ph_q    <= (nstate == state)
              && ((state == READ) || (state == WRITE));
      rec_cnt <= (state == REC) ? rec_cnt + 32'd1 : '0;
      tmo_cnt <= (state == WWAIT) ? tmo_cnt + 32'd1 : '0;
      ack_q   <= (nstate == ACK);
      rd_rs_q <= (state == RDRS);
      read_q  <= (state == RDRS) ? data_q : '0;
      unique case (state)
        IDLE: begin
          if (sel_hit) begin
            addr_q <= m_ma[ADDR_BITS-1:0];
            rd_q   <= m_rd_rq;
            wr_q   <= m_wr_rq;
            data_q <= '0;
          end
        end
        READ: if (ph_q) data_q <= ram_q;
        // The write word replaces the read word on RMW.
        RDRS: if (wr_q) data_q <= '0;
        WWAIT: data_q <= data_q | m_mb_write;
        WRITE: if (!ph_q) data_q <= data_q | m_mb_write;
        default: ;
      endcase
    end
  end

  assign m_addr_ack = ack_q;
  assign m_rd_rs    = rd_rs_q;
  assign m_mb_read  = read_q;

endmodule

// File: tb/tb_core_mem_slave.sv
// tb_core_mem_slave: scoreboarded bench for core_mem_slave.
// Reads push expected words; the negedge monitor pops them on m_rd_rs.
module tb_core_mem_slave;

  localparam logic [3:0] SEL = 4'o0;
  localparam int AB  = 14;
  localparam int REC = 12;
  localparam int TMO = 255;

  logic        clk = 1'b0;
  logic        reset;
  logic        m_rq_cyc;
  logic        m_rd_rq;
  logic        m_wr_rq;
  logic [14:0] m_ma;
  logic [3:0]  m_sel;
  logic        m_fmc_select;
  logic [35:0] m_mb_write;
  logic        m_wr_rs;
  logic [35:0] m_mb_read;
  logic        m_addr_ack;
  logic        m_rd_rs;

  core_mem_slave #(
    .SEL(SEL), .ADDR_BITS(AB), .REC_CYC(REC), .WR_TMO(TMO)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .m_rq_cyc     (m_rq_cyc),
    .m_rd_rq      (m_rd_rq),
    .m_wr_rq      (m_wr_rq),
    .m_ma         (m_ma),
    .m_sel        (m_sel),
    .m_fmc_select (m_fmc_select),
    .m_mb_write   (m_mb_write),
    .m_wr_rs      (m_wr_rs),
    .m_mb_read    (m_mb_read),
    .m_addr_ack   (m_addr_ack),
    .m_rd_rs      (m_rd_rs)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag,
                       input logic [35:0] got,
                       input logic [35:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0o want %0o", tag, got, exp);
    end
  endtask

  logic [35:0] sb[$];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int rdrs_cnt = 0;
  int ack_rises = 0;
  int last_rise = 0;
  int last_fall = 0;
  int last_rdrs = 0;
  int stray = 0;
  int dbl = 0;
  int unexp = 0;
  int t_req = 0;
  logic ack_p = 1'b0;
  logic rdrs_p = 1'b0;

  always @(negedge clk) begin
    if (m_addr_ack === 1'b1 && ack_p !== 1'b1) begin
      last_rise = cyc;
      ack_rises++;
    end
    if (m_addr_ack === 1'b0 && ack_p === 1'b1) last_fall = cyc;
    if (m_rd_rs === 1'b1) begin
      rdrs_cnt++;
      last_rdrs = cyc;
      if (rdrs_p === 1'b1) dbl++;
      if (sb.size() == 0) unexp++;
      else check("rd_data", m_mb_read, sb.pop_front());
    end else if (m_mb_read !== 36'd0 && reset === 1'b1) begin
      stray++;
    end
    ack_p  = m_addr_ack;
    rdrs_p = m_rd_rs;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic rd, input logic wr,
                     input logic [14:0] ma, input logic [3:0] sel,
                     input logic fmc, input int bound,
                     output bit acked);
    m_rq_cyc = 1'b1;
    m_rd_rq = rd;
    m_wr_rq = wr;
    m_ma = ma;
    m_sel = sel;
    m_fmc_select = fmc;
    acked = 1'b0;
    for (int i = 0; i < bound && !acked; i++) begin
      @(negedge clk);
      acked = (m_addr_ack === 1'b1);
    end
    step();
    m_rq_cyc = 1'b0;
    m_rd_rq = 1'b0;
    m_wr_rq = 1'b0;
  endtask

  task automatic wpulse(input logic [35:0] w);
    m_wr_rs = 1'b1;
    m_mb_write = w;
    step();
    m_wr_rs = 1'b0;
    step();
    m_mb_write = '0;
  endtask

  task automatic wait_rdrs(input int n);
    for (int i = 0; i < 40 && rdrs_cnt <= n; i++) @(negedge clk);
    check("rdrs_seen", 36'(rdrs_cnt), 36'(n + 1));
  endtask

  task automatic write(input logic [14:0] ma, input logic [35:0] w);
    bit a;
    req(1'b0, 1'b1, ma, SEL, 1'b0, 400, a);
    check("wr_ack", 36'(a), 36'd1);
    step();
    step();
    wpulse(w);
    repeat (REC + 4) step();
  endtask

  task automatic read(input logic [14:0] ma, input logic [35:0] exp);
    bit a;
    int n;
    sb.push_back(exp);
    n = rdrs_cnt;
    t_req = cyc;
    req(1'b1, 1'b0, ma, SEL, 1'b0, 400, a);
    check("rd_ack", 36'(a), 36'd1);
    wait_rdrs(n);
    repeat (REC + 4) step();
  endtask

  task automatic rmw(input logic [14:0] ma, input logic [35:0] exp,
                     input logic [35:0] w);
    bit a;
    int n;
    sb.push_back(exp);
    n = rdrs_cnt;
    req(1'b1, 1'b1, ma, SEL, 1'b0, 400, a);
    check("rmw_ack", 36'(a), 36'd1);
    wait_rdrs(n);
    step();
    wpulse(w);
    repeat (REC + 4) step();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog cyc %0d limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int n;
    int na;
    int r1;
    reset = 1'b0;
    m_rq_cyc = 1'b0;
    m_rd_rq = 1'b0;
    m_wr_rq = 1'b0;
    m_ma = '0;
    m_sel = SEL;
    m_fmc_select = 1'b0;
    m_mb_write = '0;
    m_wr_rs = 1'b0;
    repeat (3) step();
    check("rst_ack", 36'(m_addr_ack), 36'd0);
    check("rst_rdrs", 36'(m_rd_rs), 36'd0);
    check("rst_read", m_mb_read, 36'd0);
    reset = 1'b1;
    step();

    // write then read back, with ack and rd_rs timing
    write(15'o1234, 36'o123456654321);
    read(15'o1234, 36'o123456654321);
    check("ack_lat", 36'(last_rise - t_req), 36'd1);
    check("rdrs_lat", 36'(last_rdrs - last_fall), 36'd3);

    // read-modify-write
    write(15'd5, 36'o777);
    rmw(15'd5, 36'o777, 36'o1);
    read(15'd5, 36'o1);

    // stray write strobes while idle, then filtered requests
    wpulse(36'o777777777777);
    step();
    na = ack_rises;
    n = rdrs_cnt;
    req(1'b1, 1'b0, 15'o1234, 4'(SEL + 4'd1), 1'b0, 20, a);
    check("flt_sel", 36'(a), 36'd0);
    req(1'b1, 1'b0, 15'o1234, SEL, 1'b1, 20, a);
    check("flt_fmc", 36'(a), 36'd0);
    req(1'b1, 1'b1, 15'o41234, SEL, 1'b0, 20, a);
    check("flt_ma", 36'(a), 36'd0);
    check("flt_ack_cnt", 36'(ack_rises), 36'(na));
    check("flt_rdrs_cnt", 36'(rdrs_cnt), 36'(n));
    read(15'o1234, 36'o123456654321);

    // write timeout stores zero; next ack waits out timeout + recovery
    write(15'd9, 36'o7777);
    req(1'b0, 1'b1, 15'd9, SEL, 1'b0, 400, a);
    check("tmo_ack", 36'(a), 36'd1);
    r1 = last_rise;
    step();
    read(15'd9, 36'd0);
    check("tmo_gap", 36'(last_rise - r1), 36'(TMO + REC + 5));

    // back-to-back reads serialised by recovery
    sb.push_back(36'o123456654321);
    sb.push_back(36'o1);
    n = rdrs_cnt;
    req(1'b1, 1'b0, 15'o1234, SEL, 1'b0, 400, a);
    check("b2b_ack1", 36'(a), 36'd1);
    r1 = last_rise;
    step();
    req(1'b1, 1'b0, 15'd5, SEL, 1'b0, 400, a);
    check("b2b_ack2", 36'(a), 36'd1);
    check("b2b_gap", 36'(last_rise - r1), 36'(REC + 6));
    wait_rdrs(n + 1);
    repeat (REC + 4) step();

    // reset while acknowledging
    write(15'd7, 36'o55);
    m_rq_cyc = 1'b1;
    m_wr_rq = 1'b1;
    m_ma = 15'd7;
    for (int i = 0; i < 10 && m_addr_ack !== 1'b1; i++) @(negedge clk);
    check("rst_ack_pre", 36'(m_addr_ack), 36'd1);
    #2;
    reset = 1'b0;
    #1;
    check("rst_ack_async", 36'(m_addr_ack), 36'd0);
    m_rq_cyc = 1'b0;
    m_wr_rq = 1'b0;
    step();
    step();
    reset = 1'b1;
    step();

    // reset in the write-wait phase
    req(1'b0, 1'b1, 15'd7, SEL, 1'b0, 400, a);
    check("rstw_ack", 36'(a), 36'd1);
    step();
    step();
    m_mb_write = 36'o1111;
    step();
    reset = 1'b0;
    #1;
    check("rstw_ack0", 36'(m_addr_ack), 36'd0);
    check("rstw_rdrs0", 36'(m_rd_rs), 36'd0);
    check("rstw_read0", m_mb_read, 36'd0);
    step();
    m_mb_write = '0;
    reset = 1'b1;
    step();
    wpulse(36'o2222);
    repeat (3) step();
    read(15'd7, 36'o55);

    check("sb_empty", 36'(sb.size()), 36'd0);
    check("rdrs_double", 36'(dbl), 36'd0);
    check("rdrs_unexp", 36'(unexp), 36'd0);
    check("stray_read", 36'(stray), 36'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
